// File: rtl/pe_bs_pkg.sv
// Shared types and helpers for the binary-serial border PE.
package pe_bs_pkg;

    // Working width of the saturating adder; operand widths up to SAT_W-1 are supported.
    localparam int unsigned SAT_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2
    } pe_bs_state_t;

    typedef struct packed {
        logic                    ovf;
        logic signed [SAT_W-1:0] sum;
    } sat_res_t;

    // Adds two values that are sign-extended from w bits. The result is either
    // wrapped to w bits or clamped to the signed w-bit range. Both forms are
    // returned sign-extended. The overflow flag is raised in either mode.
    function automatic sat_res_t sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             w,
        input logic                    sat
    );
        logic signed [SAT_W-1:0] full;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] wrapped;
        sat_res_t                r;
        full    = a + b;
        hi      = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
        lo      = ~hi;
        wrapped = (full <<< (SAT_W - w)) >>> (SAT_W - w);
        r.ovf   = (full > hi) || (full < lo);
        r.sum   = (sat && r.ovf) ? (full[SAT_W-1] ? lo : hi) : wrapped;
        return r;
    endfunction

endpackage

// File: rtl/mul_bs_serial.sv
// Serial shift-add multiplier: consumes BPC ifm bits per cycle, LSB chunk first.
module mul_bs_serial
    import pe_bs_pkg::*;
#(
    parameter int unsigned IWIDTH = 8,
    parameter int unsigned BPC    = 1,
    parameter int unsigned IDEPTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     step,
    input  logic                     abort,
    input  logic                     signed_in,
    input  logic [IWIDTH-1:0]        ifm,
    input  logic [IWIDTH-1:0]        wght,
    output logic signed [2*IWIDTH:0] prod,
    output logic [IDEPTH-1:0]        idx,
    output logic                     last
);

    localparam int unsigned NCYC = IWIDTH / BPC;
    localparam int unsigned PW   = 2 * IWIDTH + 1;

    logic [IWIDTH-1:0]    ifm_s;
    logic [IWIDTH-1:0]    wght_s;
    logic                 sgn_s;
    logic [IDEPTH-1:0]    cnt;
    logic [BPC-1:0]       chunk;
    logic                 top;
    logic signed [PW-1:0] wext;
    logic signed [PW-1:0] cext;
    logic signed [PW-1:0] term;

    // Chunk select and weighted partial product. Only the top chunk carries the sign.
    always_comb begin
        top   = (cnt == IDEPTH'(NCYC - 1));
        chunk = ifm_s[cnt*BPC +: BPC];
        wext  = {{(PW-IWIDTH){sgn_s & wght_s[IWIDTH-1]}}, wght_s};
        cext  = {{(PW-BPC){sgn_s & top & chunk[BPC-1]}}, chunk};
        term  = (wext * cext) <<< (cnt * BPC);
    end

    assign idx  = cnt;
    assign last = top;

    // Snapshot operands on start, then add one partial product per step.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            ifm_s  <= '0;
            wght_s <= '0;
            sgn_s  <= 1'b0;
            cnt    <= '0;
            prod   <= '0;
        end else if (start) begin
            ifm_s  <= ifm;
            wght_s <= wght;
            sgn_s  <= signed_in;
            cnt    <= '0;
            prod   <= '0;
        end else if (step) begin
            prod <= prod + term;
            cnt  <= top ? '0 : cnt + IDEPTH'(1);
        end
    end

endmodule

// File: rtl/pe_bs_border.sv
// Border PE: operand registers, control forwarding, multiply/accumulate FSM and psum output.
module pe_bs_border
    import pe_bs_pkg::*;
#(
    parameter int unsigned IWIDTH = 8,
    parameter int unsigned BPC    = 1,
    parameter int unsigned IDEPTH = 3,
    parameter int unsigned OWIDTH = 24,
    parameter bit          SAT    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_mode,
    input  logic              mac_done,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic              en_w,
    input  logic              clr_w,
    input  logic              en_o,
    input  logic              clr_o,
    input  logic [IWIDTH-1:0] ifm,
    input  logic [IWIDTH-1:0] wght,
    input  logic [OWIDTH-1:0] ofm,
    output logic [IDEPTH-1:0] idx_d,
    output logic              mac_done_d,
    output logic              en_i_d,
    output logic              clr_i_d,
    output logic              en_w_d,
    output logic              clr_w_d,
    output logic              en_o_d,
    output logic              clr_o_d,
    output logic [IWIDTH-1:0] ifm_d,
    output logic [IWIDTH-1:0] wght_d,
    output logic [OWIDTH-1:0] ofm_d,
    output logic              busy,
    output logic              ovf
);

    localparam int unsigned PW = 2 * IWIDTH + 1;

    pe_bs_state_t             state;
    logic signed [OWIDTH-1:0] acc;
    logic                     done_pend;
    logic signed [PW-1:0]     prod;
    logic [IDEPTH-1:0]        mul_idx;
    logic                     mul_last;
    logic                     mul_start;
    logic                     mul_step;
    logic signed [OWIDTH-1:0] prod_ext;
    logic [OWIDTH:0]          s_acc;
    logic [OWIDTH:0]          s_done;
    logic [OWIDTH:0]          s_idle;

    // OWIDTH-wide add; result is {overflow, sum}.
    function automatic logic [OWIDTH:0] add_w(
        input logic signed [OWIDTH-1:0] a,
        input logic signed [OWIDTH-1:0] b
    );
        sat_res_t r;
        r = sat_add(SAT_W'(a), SAT_W'(b), OWIDTH, SAT);
        return {r.ovf, r.sum[OWIDTH-1:0]};
    endfunction

    assign mul_start = en_o && !clr_o && (state == IDLE || state == ACC);
    assign mul_step  = (state == MUL) && !clr_o;
    assign busy      = (state != IDLE);
    assign idx_d     = (state == MUL) ? mul_idx : '0;

    mul_bs_serial #(
        .IWIDTH (IWIDTH),
        .BPC    (BPC),
        .IDEPTH (IDEPTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start     (mul_start),
        .step      (mul_step),
        .abort     (clr_o),
        .signed_in (signed_mode),
        .ifm       (ifm_d),
        .wght      (wght_d),
        .prod      (prod),
        .idx       (mul_idx),
        .last      (mul_last)
    );

    // Accumulate, accumulate+psum and idle psum sums, each with its overflow bit.
    always_comb begin
        prod_ext = OWIDTH'(prod);
        s_acc    = add_w(acc, prod_ext);
        s_done   = add_w(s_acc[OWIDTH-1:0], $signed(ofm));
        s_idle   = add_w(acc, $signed(ofm));
    end

    // Operand registers: clear wins over load.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifm_d  <= '0;
            wght_d <= '0;
        end else begin
            if (clr_i)     ifm_d <= '0;
            else if (en_i) ifm_d <= ifm;
            if (clr_w)     wght_d <= '0;
            else if (en_w) wght_d <= wght;
        end
    end

    // One-cycle forwarding of all control lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_done_d <= 1'b0;
            en_i_d     <= 1'b0;
            clr_i_d    <= 1'b0;
            en_w_d     <= 1'b0;
            clr_w_d    <= 1'b0;
            en_o_d     <= 1'b0;
            clr_o_d    <= 1'b0;
        end else begin
            mac_done_d <= mac_done;
            en_i_d     <= en_i;
            clr_i_d    <= clr_i;
            en_w_d     <= en_w;
            clr_w_d    <= clr_w;
            en_o_d     <= en_o;
            clr_o_d    <= clr_o;
        end
    end

    // Control FSM with accumulator, deferred completion and sticky overflow.
    // A mac_done_d seen during MUL is parked in done_pend so that the product
    // still in flight gets folded into the same psum in the ACC cycle.
    always_ff @(posedge clk) begin
        if (rst || clr_o) begin
            state     <= IDLE;
            acc       <= '0;
            done_pend <= 1'b0;
            ofm_d     <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mac_done_d) begin
                        ofm_d <= s_idle[OWIDTH-1:0];
                        acc   <= '0;
                        ovf   <= ovf | s_idle[OWIDTH];
                    end
                    if (en_o) state <= MUL;
                end
                MUL: begin
                    if (mac_done_d) done_pend <= 1'b1;
                    if (mul_last)   state     <= ACC;
                end
                ACC: begin
                    if (mac_done_d || done_pend) begin
                        ofm_d     <= s_done[OWIDTH-1:0];
                        acc       <= '0;
                        done_pend <= 1'b0;
                        ovf       <= ovf | s_acc[OWIDTH] | s_done[OWIDTH];
                    end else begin
                        acc <= s_acc[OWIDTH-1:0];
                        ovf <= ovf | s_acc[OWIDTH];
                    end
                    state <= en_o ? MUL : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_bs_border.sv
// Directed bench for pe_bs_border: three instances (BPC=2 wide, BPC=1 saturating, BPC=1 wrapping)
// share one stimulus stream; each check targets the instance the scenario is about.
module tb_pe_bs_border;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, signed_mode, mac_done, en_i, clr_i, en_w, clr_w, en_o, clr_o;
    logic [7:0]  ifm, wght;
    logic [23:0] ofm;

    logic [1:0]  a_idx;
    logic [2:0]  s_idx, w_idx;
    logic [6:0]  a_ctl, s_ctl, w_ctl;
    logic [7:0]  a_ifm, a_wght, s_ifm, s_wght, w_ifm, w_wght;
    logic [23:0] a_ofm;
    logic [16:0] s_ofm, w_ofm;
    logic        a_busy, a_ovf, s_busy, s_ovf, w_busy, w_ovf;

    pe_bs_border #(.IWIDTH(8), .BPC(2), .IDEPTH(2), .OWIDTH(24), .SAT(1'b0)) u_a (
        .clk(clk), .rst(rst), .signed_mode(signed_mode), .mac_done(mac_done),
        .en_i(en_i), .clr_i(clr_i), .en_w(en_w), .clr_w(clr_w), .en_o(en_o), .clr_o(clr_o),
        .ifm(ifm), .wght(wght), .ofm(ofm), .idx_d(a_idx),
        .mac_done_d(a_ctl[6]), .en_i_d(a_ctl[5]), .clr_i_d(a_ctl[4]), .en_w_d(a_ctl[3]),
        .clr_w_d(a_ctl[2]), .en_o_d(a_ctl[1]), .clr_o_d(a_ctl[0]),
        .ifm_d(a_ifm), .wght_d(a_wght), .ofm_d(a_ofm), .busy(a_busy), .ovf(a_ovf)
    );

    pe_bs_border #(.IWIDTH(8), .BPC(1), .IDEPTH(3), .OWIDTH(17), .SAT(1'b1)) u_s (
        .clk(clk), .rst(rst), .signed_mode(signed_mode), .mac_done(mac_done),
        .en_i(en_i), .clr_i(clr_i), .en_w(en_w), .clr_w(clr_w), .en_o(en_o), .clr_o(clr_o),
        .ifm(ifm), .wght(wght), .ofm(ofm[16:0]), .idx_d(s_idx),
        .mac_done_d(s_ctl[6]), .en_i_d(s_ctl[5]), .clr_i_d(s_ctl[4]), .en_w_d(s_ctl[3]),
        .clr_w_d(s_ctl[2]), .en_o_d(s_ctl[1]), .clr_o_d(s_ctl[0]),
        .ifm_d(s_ifm), .wght_d(s_wght), .ofm_d(s_ofm), .busy(s_busy), .ovf(s_ovf)
    );

    pe_bs_border #(.IWIDTH(8), .BPC(1), .IDEPTH(3), .OWIDTH(17), .SAT(1'b0)) u_w (
        .clk(clk), .rst(rst), .signed_mode(signed_mode), .mac_done(mac_done),
        .en_i(en_i), .clr_i(clr_i), .en_w(en_w), .clr_w(clr_w), .en_o(en_o), .clr_o(clr_o),
        .ifm(ifm), .wght(wght), .ofm(ofm[16:0]), .idx_d(w_idx),
        .mac_done_d(w_ctl[6]), .en_i_d(w_ctl[5]), .clr_i_d(w_ctl[4]), .en_w_d(w_ctl[3]),
        .clr_w_d(w_ctl[2]), .en_o_d(w_ctl[1]), .clr_o_d(w_ctl[0]),
        .ifm_d(w_ifm), .wght_d(w_wght), .ofm_d(w_ofm), .busy(w_busy), .ovf(w_ovf)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                      tag, $signed(got), got, $signed(exp), exp);
    endtask

    // Advance n clock edges; outputs are then stable for sampling and inputs may change.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [7:0] i_v, input logic [7:0] w_v);
        ifm = i_v; wght = w_v; en_i = 1'b1; en_w = 1'b1;
        tick();
        en_i = 1'b0; en_w = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_o = 1'b1;
        tick();
        clr_o = 1'b0;
    endtask

    initial begin
        rst = 1'b0; signed_mode = 1'b0; mac_done = 1'b0;
        en_i = 1'b0; clr_i = 1'b0; en_w = 1'b0; clr_w = 1'b0; en_o = 1'b0; clr_o = 1'b0;
        ifm = '0; wght = '0; ofm = '0;
        #2;

        // 1: reset with random inputs
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            {signed_mode, mac_done, en_i, clr_i, en_w, clr_w, en_o, clr_o} = 8'($urandom);
            ifm = 8'($urandom); wght = 8'($urandom); ofm = 24'($urandom);
            tick();
        end
        check("rst_a", {a_ofm, a_ifm, a_wght, a_busy, a_ovf, a_idx, a_ctl}, 64'd0);
        check("rst_s", {s_ofm, s_ifm, s_wght, s_busy, s_ovf, s_idx, s_ctl}, 64'd0);
        check("rst_w", {w_ofm, w_ifm, w_wght, w_busy, w_ovf, w_idx, w_ctl}, 64'd0);
        rst = 1'b0;
        {signed_mode, mac_done, en_i, clr_i, en_w, clr_w, en_o, clr_o} = '0;
        ifm = '0; wght = '0; ofm = '0;
        tick();
        check("idle_after_rst", {a_busy, s_busy, w_busy}, 64'd0);

        // 2: BPC=2 signed -3 * 5
        load(8'hFD, 8'd5);
        check("ifm_d_load", a_ifm, 64'hFD);
        check("wght_d_load", a_wght, 64'd5);
        en_o = 1'b1; signed_mode = 1'b1;
        tick();
        en_o = 1'b0; signed_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b2_busy_mul%0d", i), a_busy, 64'd1);
            check($sformatf("b2_idx%0d", i), a_idx, 64'(i));
            tick();
        end
        check("b2_busy_acc", a_busy, 64'd1);
        check("b2_idx_acc", a_idx, 64'd0);
        tick();
        check("b2_busy_done", a_busy, 64'd0);
        check("b2_acc", u_a.acc, -64'sd15);
        mac_done = 1'b1; ofm = 24'd100;
        tick();
        mac_done = 1'b0;
        tick();
        check("b2_psum", a_ofm, 64'd85);
        check("b2_acc_cleared", u_a.acc, 64'd0);

        // 3: BPC=1 unsigned 255 * 255, acc lands exactly 10 cycles after start
        pulse_clr();
        load(8'hFF, 8'hFF);
        en_o = 1'b1; signed_mode = 1'b0;
        tick();
        en_o = 1'b0;
        tick(8);
        check("u8_acc_not_yet", u_w.acc, 64'd0);
        check("u8_busy_acc", w_busy, 64'd1);
        tick();
        check("u8_acc", u_w.acc, 64'd65025);
        check("u8_busy_done", w_busy, 64'd0);
        check("u8_acc_sat", u_s.acc, 64'd65025);
        check("u8_ovf_sat", s_ovf, 64'd0);
        check("u8_acc_b2", u_a.acc, 64'd65025);

        // 4: five products of -128 * -128 into 17-bit accumulators
        pulse_clr();
        load(8'h80, 8'h80);
        for (int p = 1; p <= 5; p++) begin
            en_o = 1'b1; signed_mode = 1'b1;
            tick();
            en_o = 1'b0;
            tick(9);
            if (p == 3) begin
                check("sat_acc_p3", u_s.acc, 64'd49152);
                check("sat_ovf_p3", s_ovf, 64'd0);
            end
            if (p == 4) begin
                check("sat_acc_p4", u_s.acc, 64'd65535);
                check("sat_ovf_p4", s_ovf, 64'd1);
                check("wrap_acc_p4", u_w.acc, -64'sd65536);
                check("wrap_ovf_p4", w_ovf, 64'd1);
            end
            if (p == 5) begin
                check("sat_acc_p5", u_s.acc, 64'd65535);
                check("wrap_acc_p5", u_w.acc, -64'sd49152);
                check("wrap_ovf_p5", w_ovf, 64'd1);
                check("wide_acc_p5", u_a.acc, 64'd81920);
                check("wide_ovf_p5", a_ovf, 64'd0);
            end
        end
        mac_done = 1'b1; ofm = 24'd1;
        tick();
        mac_done = 1'b0;
        tick();
        check("sat_psum", s_ofm, 64'd65535);
        check("sat_ovf_psum", s_ovf, 64'd1);
        check("wrap_psum", w_ofm, 64'd81921);
        check("wide_psum", a_ofm, 64'd81921);

        // 6: abort in the middle of a multiply, plus control forwarding latency
        en_o = 1'b1;
        tick();
        en_o = 1'b0;
        tick(9);
        check("abort_pre_acc", u_s.acc, 64'd16384);
        en_o = 1'b1;
        tick();
        check("en_o_d_high", w_ctl[1], 64'd1);
        en_o = 1'b0;
        tick();
        check("en_o_d_low", w_ctl[1], 64'd0);
        tick();
        check("abort_idx", w_idx, 64'd2);
        clr_o = 1'b1;
        check("clr_o_d_before", w_ctl[0], 64'd0);
        tick();
        clr_o = 1'b0;
        check("clr_o_d_high", w_ctl[0], 64'd1);
        check("abort_s", {s_busy, s_ovf, s_ofm, s_idx}, 64'd0);
        check("abort_s_acc", u_s.acc, 64'd0);
        check("abort_w", {w_busy, w_ovf, w_ofm, w_idx}, 64'd0);
        check("abort_w_acc", u_w.acc, 64'd0);
        tick();
        check("clr_o_d_low", w_ctl[0], 64'd0);

        // 5: mac_done during MUL step 1 of 7*9 with acc=10, ofm=1
        pulse_clr();
        load(8'd2, 8'd5);
        en_o = 1'b1; signed_mode = 1'b0;
        tick();
        en_o = 1'b0;
        tick(9);
        check("pend_acc10", u_w.acc, 64'd10);
        load(8'd7, 8'd9);
        en_o = 1'b1;
        tick();
        en_o = 1'b0;
        tick();
        check("pend_idx1", w_idx, 64'd1);
        mac_done = 1'b1; ofm = 24'd1;
        tick();
        mac_done = 1'b0;
        tick(6);
        check("pend_in_acc", {w_busy, w_idx}, 64'h8);
        check("pend_ofm_not_yet", w_ofm, 64'd0);
        tick();
        check("pend_psum", w_ofm, 64'd74);
        check("pend_acc_cleared", u_w.acc, 64'd0);
        check("pend_busy_done", w_busy, 64'd0);
        check("pend_psum_sat", s_ofm, 64'd74);
        check("pend_psum_b2", a_ofm, 64'd74);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
